wb_arbiter_2m: RTL and testbench
================================

# wb_arbiter_2m

Two-master Wishbone arbiter placed in front of the Wishbone-to-AXI bridge so that two Wishbone masters can share the single AXI master port into the PS7 (for example, the CPU data bus and a DMA engine). Each master's bus cycle is granted for its whole duration (`cyc` high). Priority is round-robin. Slave responses go only to the owning master. An optional watchdog aborts transfers that never complete.

## Interface

Parameters:
- `DATA_WIDTH`, 32, Wishbone data width; byte-select width is `DATA_WIDTH/8`.
- `ADDR_WIDTH`, 32, Wishbone address width.
- `TIMEOUT_CYCLES`, 255, watchdog limit in cycles; legal range 1..65535. Used only when the watchdog is compiled in.

Ports:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 cycle, strobe, write enable.
- `m0_adr_i`  in  `ADDR_WIDTH`  master 0 address.
- `m0_dat_i`  in  `DATA_WIDTH`  master 0 write data.
- `m0_sel_i`  in  `DATA_WIDTH/8`  master 0 byte selects.
- `m0_cti_i`  in  3  master 0 cycle type.
- `m0_bte_i`  in  2  master 0 burst type.
- `m0_ack_o`, `m0_err_o`, `m0_rty_o`  out  1 each  responses to master 0.
- `m0_dat_o`  out  `DATA_WIDTH`  read data to master 0.
- `m1_*`  same set, directions and widths as `m0_*`, for master 1.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_cti_o`, `s_bte_o`  out  slave-side request signals, widths as the matching master inputs; these connect to the bridge.
- `s_ack_i`, `s_err_i`, `s_rty_i`  in  1 each  slave responses.
- `s_dat_i`  in  `DATA_WIDTH`  slave read data.
- `grant_o`  out  2  one-hot current owner; `2'b00` when idle.

## Operation

State machine states: IDLE, OWN0, OWN1. A round-robin pointer `last` records the most recently granted master.

IDLE:
- Only `m0_cyc_i` high: go to OWN0.
- Only `m1_cyc_i` high: go to OWN1.
- Both high: grant the master that is not `last`.
- On every grant, set `last` to the granted master.

OWNx:
- Stay while `mx_cyc_i` is high.
- When `mx_cyc_i` is low, return to IDLE.
- The other master's `cyc` is ignored while in OWNx.

Request mux:
- In OWNx, all `s_*_o` request outputs equal the `mx_*_i` inputs (combinational).
- In IDLE, `s_cyc_o` and `s_stb_o` are 0; the other `s_*_o` outputs carry master 0 inputs, value don't-care.

Response routing:
- `mx_ack_o`, `mx_err_o`, `mx_rty_o` equal `s_*_i` gated by OWNx.
- The non-owner master and the idle state see 0 on all responses.
- `m0_dat_o` and `m1_dat_o` both equal `s_dat_i`, ungated.

Reset:
- All state is cleared: state IDLE, `last` = master 1 so that master 0 wins the first tie, watchdog counter 0.
- Reset mid-transfer drops `s_cyc_o` in the cycle after the reset edge.

## Timing

- Grant latency: a master's `cyc` sampled high in IDLE at edge N gives ownership, and `s_cyc_o` high, from edge N+1. Zero-wait grant is not provided.
- Release: the owner dropping `cyc` before edge N gives IDLE at N+1. There is exactly one dead cycle between successive grants, so back-to-back tenures from alternating masters are spaced by one idle cycle.
- Simultaneous request while IDLE: round-robin decides. Simultaneous release by one master and request by the other: the other is granted after the IDLE cycle.
- Response path is purely combinational; no added latency.
- Reset values of outputs:
  - `grant_o` = 0, `s_cyc_o` = 0, `s_stb_o` = 0.
  - All `mx_ack_o`, `mx_err_o`, `mx_rty_o` = 0.
  - Data, address and select outputs follow their mux inputs.

## Configuration

Macro: `WB_ARB_TIMEOUT_EN`.

When defined:
- A 16-bit counter increments every cycle with `s_cyc_o & s_stb_o & !(s_ack_i | s_err_i | s_rty_i)`. It clears on any response or in IDLE.
- When the count reaches `TIMEOUT_CYCLES`, the owner receives `mx_err_o` = 1 for exactly one cycle and an abort flag is set.
- While the abort flag is set:
  - `s_cyc_o` and `s_stb_o` are forced to 0.
  - Owner responses are forced to 0, so late slave responses are discarded.
- The abort flag clears when the owner drops `cyc`. The state then returns to IDLE as normal.

When not defined:
- No counter or abort logic is present.
- A transfer that never completes holds the grant indefinitely.

## Test plan

- Reset, then master 0 single write to 0x1000 with data 0xDEADBEEF and slave ack after 3 cycles:
  - `s_cyc_o` rises 1 cycle after `m0_cyc_i`;
  - `m0_ack_o` = 1 for one cycle; `m1_ack_o` stays 0;
  - `grant_o` goes 01, then 00.
- Both masters raise `cyc` in the same cycle, right after reset:
  - master 0 is granted first;
  - master 1 is granted after one idle cycle;
  - next tie goes to master 0 again.
- Master 1 owns and holds `cyc` for 10 cycles while master 0 requests:
  - `s_adr_o` tracks master 1 throughout;
  - master 0 sees no responses;
  - master 0 is granted after master 1 releases, plus one idle cycle.
- Read with slave returning 0x12345678 plus `s_err_i`:
  - `m0_err_o` = 1, `m0_ack_o` = 0;
  - `m0_dat_o` = 0x12345678.
- With `WB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8 and a slave that never acks:
  - `m0_err_o` pulses on the 8th stalled cycle;
  - `s_cyc_o` is 0 from the next cycle;
  - a late `s_ack_i` is not forwarded.
- Assert `rst` mid-transfer while master 1 owns:
  - `grant_o` = 0 and `s_cyc_o` = 0 after the edge;
  - the next tie is granted to master 0.

Source files
------------

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone arbiter: round-robin on cyc, whole-cycle tenure, grant one cycle after request, combinational mux/response paths.
// Losers wait with cyc high; the owner is stalled only by the slave. Watchdog abort compiled in with WB_ARB_TIMEOUT_EN.
module wb_arbiter_2m #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [ADDR_WIDTH-1:0]     m0_adr_i,
    input  logic [DATA_WIDTH-1:0]     m0_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
    input  logic [2:0]                m0_cti_i,
    input  logic [1:0]                m0_bte_i,
    output logic                      m0_ack_o,
    output logic                      m0_err_o,
    output logic                      m0_rty_o,
    output logic [DATA_WIDTH-1:0]     m0_dat_o,

    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [ADDR_WIDTH-1:0]     m1_adr_i,
    input  logic [DATA_WIDTH-1:0]     m1_dat_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
    input  logic [2:0]                m1_cti_i,
    input  logic [1:0]                m1_bte_i,
    output logic                      m1_ack_o,
    output logic                      m1_err_o,
    output logic                      m1_rty_o,
    output logic [DATA_WIDTH-1:0]     m1_dat_o,

    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [ADDR_WIDTH-1:0]     s_adr_o,
    output logic [DATA_WIDTH-1:0]     s_dat_o,
    output logic [DATA_WIDTH/8-1:0]   s_sel_o,
    output logic [2:0]                s_cti_o,
    output logic [1:0]                s_bte_o,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    input  logic [DATA_WIDTH-1:0]     s_dat_i,

    output logic [1:0]                grant_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_q, last_d;
    logic   own0, own1;
    logic   owner_cyc, owner_stb;
    logic   wd_kill, wd_err;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter_2m: TIMEOUT_CYCLES must be within 1..65535");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // last_q names the master granted most recently; a tie goes to the other one.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = ST_OWN0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = ST_OWN1;
                    last_d  = 1'b1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign own0      = (state_q == ST_OWN0);
    assign own1      = (state_q == ST_OWN1);
    assign owner_cyc = (own0 & m0_cyc_i) | (own1 & m1_cyc_i);
    assign owner_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        abort_q, abort_d;
    logic        wd_fire;
    logic        s_rsp;

    assign s_rsp = s_ack_i | s_err_i | s_rty_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= 16'd0;
            abort_q  <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            abort_q  <= abort_d;
        end
    end

    // Fires on the stalled cycle that would bring the count to TIMEOUT_CYCLES.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        abort_d  = abort_q;
        wd_fire  = 1'b0;
        if (!owner_cyc) begin
            wd_cnt_d = 16'd0;
            abort_d  = 1'b0;
        end else if (abort_q || s_rsp) begin
            wd_cnt_d = 16'd0;
        end else if (owner_stb) begin
            if (wd_cnt_q == WD_LAST) begin
                wd_fire  = 1'b1;
                abort_d  = 1'b1;
                wd_cnt_d = 16'd0;
            end else begin
                wd_cnt_d = wd_cnt_q + 16'd1;
            end
        end
    end

    assign wd_kill = abort_q;
    assign wd_err  = wd_fire;
`else
    assign wd_kill = 1'b0;
    assign wd_err  = 1'b0;
`endif

    always_comb begin
        grant_o = {own1, own0};
        s_cyc_o = owner_cyc & ~wd_kill;
        s_stb_o = owner_stb & ~wd_kill;
        if (own1) begin
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_cti_o = m1_cti_i;
            s_bte_o = m1_bte_i;
        end else begin
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_cti_o = m0_cti_i;
            s_bte_o = m0_bte_i;
        end
        m0_ack_o = own0 & ~wd_kill & s_ack_i;
        m0_err_o = own0 & ((~wd_kill & s_err_i) | wd_err);
        m0_rty_o = own0 & ~wd_kill & s_rty_i;
        m1_ack_o = own1 & ~wd_kill & s_ack_i;
        m1_err_o = own1 & ((~wd_kill & s_err_i) | wd_err);
        m1_rty_o = own1 & ~wd_kill & s_rty_i;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: grant changes and response pulses are queued as expectations and matched by a monitor.
`timescale 1ns/1ps
module tb_wb_arbiter_2m;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
    logic [3:0]  m0_sel, m1_sel;
    logic [2:0]  m0_cti, m1_cti;
    logic [1:0]  m0_bte, m1_bte;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic        s_ack_i, s_err_i, s_rty_i;
    logic [31:0] s_dat_i;
    logic [1:0]  grant_o;
    logic [5:0]  rsp_vec;

    wb_arbiter_2m #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_cti_i(m0_cti), .m0_bte_i(m0_bte),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_cti_i(m1_cti), .m1_bte_i(m1_bte),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    assign rsp_vec = {m1_ack_o, m1_err_o, m1_rty_o, m0_ack_o, m0_err_o, m0_rty_o};

    typedef struct packed {
        logic        is_rsp;
        logic [5:0]  tag;
        logic [31:0] dat;
    } ev_t;

    ev_t        exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic       mon_en = 1'b0;
    logic [1:0] prev_grant = 2'b00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic exp_grant(input logic [1:0] g);
        ev_t e;
        e.is_rsp = 1'b0;
        e.tag    = {4'b0000, g};
        e.dat    = 32'h0;
        exp_q.push_back(e);
    endtask

    // tag bits: {m1 ack, m1 err, m1 rty, m0 ack, m0 err, m0 rty}
    task automatic exp_rsp(input logic [5:0] tag, input logic [31:0] dat);
        ev_t e;
        e.is_rsp = 1'b1;
        e.tag    = tag;
        e.dat    = dat;
        exp_q.push_back(e);
    endtask

    task automatic take(input logic is_rsp, input logic [5:0] tag);
        ev_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got rsp=%0b tag=%b want no event", is_rsp, tag);
        end else begin
            e = exp_q.pop_front();
            chk("evt_kind", 32'(is_rsp), 32'(e.is_rsp));
            chk(is_rsp ? "rsp_tag" : "grant_seq", 32'(tag), 32'(e.tag));
            if (is_rsp) begin
                chk("rsp_m0_dat", m0_dat_o, e.dat);
                chk("rsp_m1_dat", m1_dat_o, e.dat);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (grant_o !== prev_grant) begin
                prev_grant = grant_o;
                take(1'b0, {4'b0000, grant_o});
            end
            if (rsp_vec !== 6'b000000) begin
                take(1'b1, rsp_vec);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat = 32'hCAFE0001;
        m0_sel = 4'hF; m0_cti = 3'b000; m0_bte = 2'b00;
        m1_sel = 4'h5; m1_cti = 3'b111; m1_bte = 2'b01;
        s_ack_i = 0; s_err_i = 0; s_rty_i = 0; s_dat_i = 32'h0;
        step(3);
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        chk("rst_s_stb", 32'(s_stb_o), 32'h0);
        chk("rst_rsp", 32'(rsp_vec), 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;

        // single write from master 0, ack on the third owned cycle
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h1000; m0_dat = 32'hDEADBEEF;
        exp_grant(2'b01);
        #1 chk("t1_no_zero_wait", 32'(s_cyc_o), 32'h0);
        step(1);
        chk("t1_s_cyc", 32'(s_cyc_o), 32'h1);
        chk("t1_adr", s_adr_o, 32'h1000);
        chk("t1_wdat", s_dat_o, 32'hDEADBEEF);
        chk("t1_we", 32'(s_we_o), 32'h1);
        chk("t1_sel", 32'(s_sel_o), 32'hF);
        step(2);
        s_ack_i = 1;
        exp_rsp(6'b000100, 32'h0);
        #1 chk("t1_m0_ack", 32'(m0_ack_o), 32'h1);
        chk("t1_m1_ack", 32'(m1_ack_o), 32'h0);
        step(1);
        s_ack_i = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        exp_grant(2'b00);
        #1 chk("t1_ack_single", 32'(m0_ack_o), 32'h0);
        step(1);
        chk("t1_grant_idle", 32'(grant_o), 32'h0);

        // simultaneous requests right after reset
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h1004;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h2000;
        exp_grant(2'b01);
        step(1);
        chk("t2_tie_first", 32'(grant_o), 32'h1);
        chk("t2_adr0", s_adr_o, 32'h1004);
        step(1);
        m0_cyc = 0; m0_stb = 0;
        exp_grant(2'b00);
        exp_grant(2'b10);
        step(1);
        chk("t2_dead_cycle", 32'(grant_o), 32'h0);
        chk("t2_dead_s_cyc", 32'(s_cyc_o), 32'h0);
        step(1);
        chk("t2_second", 32'(grant_o), 32'h2);
        chk("t2_adr1", s_adr_o, 32'h2000);
        chk("t2_cti1", 32'(s_cti_o), 32'h7);
        chk("t2_wdat1", s_dat_o, 32'hCAFE0001);
        m0_cyc = 1; m0_stb = 1;
        step(1);
        chk("t2_hold", 32'(grant_o), 32'h2);
        m1_cyc = 0; m1_stb = 0;
        exp_grant(2'b00);
        exp_grant(2'b01);
        step(1);
        m1_cyc = 1; m1_stb = 1;
        step(1);
        chk("t2_tie_rr", 32'(grant_o), 32'h1);
        m0_cyc = 0; m0_stb = 0;
        exp_grant(2'b00);
        exp_grant(2'b10);
        step(2);
        chk("t2_m1_again", 32'(grant_o), 32'h2);

        // master 1 holds its tenure while master 0 waits
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h11110000;
        for (int i = 0; i < 10; i++) begin
            m1_adr  = 32'h2000 + 32'(i * 4);
            s_ack_i = (i % 3 == 1);
            s_rty_i = (i == 8);
            s_dat_i = 32'hA000 + 32'(i);
            if (i % 3 == 1) exp_rsp(6'b100000, 32'hA000 + 32'(i));
            if (i == 8) exp_rsp(6'b001000, 32'hA000 + 32'(i));
            #1 chk("t3_adr_track", s_adr_o, 32'h2000 + 32'(i * 4));
            chk("t3_m0_quiet", 32'({m0_ack_o, m0_err_o, m0_rty_o}), 32'h0);
            step(1);
        end
        s_ack_i = 0; s_rty_i = 0; s_dat_i = 32'h0;
        m1_cyc = 0; m1_stb = 0;
        exp_grant(2'b00);
        exp_grant(2'b01);
        step(1);
        chk("t3_dead_cycle", 32'(grant_o), 32'h0);
        step(1);
        chk("t3_m0_granted", 32'(grant_o), 32'h1);
        chk("t3_adr0", s_adr_o, 32'h11110000);

        // read completing with an error and data
        m0_we = 0; m0_adr = 32'h3000;
        step(1);
        s_dat_i = 32'h12345678; s_err_i = 1;
        exp_rsp(6'b000010, 32'h12345678);
        #1 chk("t4_m0_err", 32'(m0_err_o), 32'h1);
        chk("t4_m0_ack", 32'(m0_ack_o), 32'h0);
        chk("t4_m0_dat", m0_dat_o, 32'h12345678);
        chk("t4_m1_dat", m1_dat_o, 32'h12345678);
        chk("t4_m1_err", 32'(m1_err_o), 32'h0);
        step(1);
        s_err_i = 0; s_dat_i = 32'h0; m0_cyc = 0; m0_stb = 0;
        exp_grant(2'b00);
        step(1);

`ifdef WB_ARB_TIMEOUT_EN
        // slave never answers: watchdog aborts on the 8th stalled cycle
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4000;
        exp_grant(2'b01);
        step(1);
        for (int i = 1; i < 8; i++) begin
            chk("t5_no_early_err", 32'(m0_err_o), 32'h0);
            step(1);
        end
        exp_rsp(6'b000010, 32'h0);
        chk("t5_err_pulse", 32'(m0_err_o), 32'h1);
        step(1);
        chk("t5_err_once", 32'(m0_err_o), 32'h0);
        chk("t5_cyc_killed", 32'(s_cyc_o), 32'h0);
        chk("t5_stb_killed", 32'(s_stb_o), 32'h0);
        chk("t5_still_owner", 32'(grant_o), 32'h1);
        s_ack_i = 1;
        #1 chk("t5_late_ack", 32'(m0_ack_o), 32'h0);
        step(1);
        s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
        exp_grant(2'b00);
        step(1);
        chk("t5_idle", 32'(grant_o), 32'h0);
`endif

        // reset while master 1 owns, then a tie
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h5000;
        exp_grant(2'b10);
        step(2);
        chk("t6_m1_owns", 32'(grant_o), 32'h2);
        rst = 1'b1;
        exp_grant(2'b00);
        step(1);
        chk("t6_rst_grant", 32'(grant_o), 32'h0);
        chk("t6_rst_s_cyc", 32'(s_cyc_o), 32'h0);
        rst = 1'b0;
        m0_cyc = 1; m0_stb = 1;
        exp_grant(2'b01);
        step(1);
        chk("t6_tie_m0", 32'(grant_o), 32'h1);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        exp_grant(2'b00);
        step(2);

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
